// File: rtl/mux_scan_n_pkg.sv
// mux_scan_n_pkg: shared definitions for the N-channel scanning multiplexer.
//   MODE_MANUAL / MODE_SCAN : encodings of the mode input
//   clog2()                 : constant ceil(log2(v)), never smaller than 1
package mux_scan_n_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Clamped to 1 so that a select or counter is always at least one bit wide.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: data, control and status bundle of mux_scan_n.
//   d       : flattened channel data, channel k at d[k*W +: W]
//   mode    : 0 manual, 1 scan
//   s_in    : manual channel select
//   en      : output update enable
//   hold    : freeze the scan sequencer (scan mode only)
//   y       : registered selected data
//   s       : channel currently selected
//   valid   : y holds d[s] sampled on a stable channel
//   wrap    : one-cycle pulse on the N-1 -> 0 scan step
//   sel_err : one-cycle pulse on an out-of-range manual select
// master: the side driving data/control; slave: the multiplexer.
interface mux_scan_n_if
    import mux_scan_n_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 1,
    parameter int unsigned SW = clog2(N)
);
    logic [N*W-1:0] d;
    logic           mode;
    logic [SW-1:0]  s_in;
    logic           en;
    logic           hold;
    logic [W-1:0]   y;
    logic [SW-1:0]  s;
    logic           valid;
    logic           wrap;
    logic           sel_err;

    modport master (
        output d, mode, s_in, en, hold,
        input  y, s, valid, wrap, sel_err
    );

    modport slave (
        input  d, mode, s_in, en, hold,
        output y, s, valid, wrap, sel_err
    );
endinterface

// File: rtl/mux_scan_n_scan_seq.sv
// mux_scan_n_scan_seq: channel sequencer of mux_scan_n.
//   clk, rst_n : clock, asynchronous active-low reset
//   mode       : 0 manual (channel from s_in), 1 scan (dwell counter drives channel)
//   s_in       : manual channel select
//   hold       : freezes dwell counter and channel in scan mode
//   s          : registered channel
//   chg        : s changes on the coming edge (combinational)
//   wrap       : registered pulse, scan stepped N-1 -> 0
//   sel_err    : registered pulse, manual select out of range
module mux_scan_n_scan_seq
    import mux_scan_n_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DWELL = 16,
    parameter int unsigned SW    = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [SW-1:0] s_in,
    input  logic          hold,
    output logic [SW-1:0] s,
    output logic          chg,
    output logic          wrap,
    output logic          sel_err
);
    localparam int unsigned CW = clog2(DWELL + 1);
    // One extra bit so the range check also works when N is a power of two.
    localparam logic [SW:0]   NumCh   = (SW + 1)'(N);
    localparam logic [SW-1:0] ChLast  = SW'(N - 1);
    localparam logic [CW-1:0] CntLast = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] s_q, s_d;
    logic          wrap_q, wrap_d;
    logic          err_q, err_d;

    always_comb begin
        s_d    = s_q;
        cnt_d  = '0;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode == MODE_MANUAL) begin
            if ({1'b0, s_in} < NumCh) begin
                s_d = s_in;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q;
            if (!hold) begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (s_q == ChLast) begin
                        s_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            s_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            s_q    <= s_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign s       = s_q;
    assign chg     = (s_d != s_q);
    assign wrap    = wrap_q;
    assign sel_err = err_q;

endmodule

// File: rtl/mux_scan_n.sv
// mux_scan_n: N-channel, W-bit multiplexer with registered output and
// manual / scanning channel selection.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_scan_n_if slave (data, mode, select, enable, hold, status)
// Y is loaded from the channel registered before the edge, so a channel change
// shows up in Y one edge later; valid drops for that one edge.
module mux_scan_n
    import mux_scan_n_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_scan_n_if.slave  bus
);
    localparam int unsigned SW = clog2(N);

    logic [SW-1:0] s;
    logic          chg;
    logic [W-1:0]  sel_data;
    logic [W-1:0]  y_q;
    logic          valid_q;

    mux_scan_n_scan_seq #(
        .N     (N),
        .DWELL (DWELL),
        .SW    (SW)
    ) u_scan_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (bus.mode),
        .s_in    (bus.s_in),
        .hold    (bus.hold),
        .s       (s),
        .chg     (chg),
        .wrap    (bus.wrap),
        .sel_err (bus.sel_err)
    );

    // Compare-based mux: only channels 0..N-1 are ever addressed.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (s == SW'(k)) sel_data = bus.d[k*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            y_q     <= sel_data;
            valid_q <= !chg;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.y     = y_q;
    assign bus.s     = s;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: scoreboard bench for mux_scan_n (N=3, W=8, DWELL=4).
// The driver applies inputs on the falling edge, advances a reference model on
// each rising edge and queues the expected outputs; the monitor pops and
// compares on the following falling edge.
module tb_mux_scan_n;
    import mux_scan_n_pkg::*;

    localparam int unsigned N     = 3;
    localparam int unsigned W     = 8;
    localparam int unsigned DWELL = 4;
    localparam int unsigned SW    = clog2(N);

    typedef struct packed {
        logic [W-1:0]  y;
        logic [SW-1:0] s;
        logic          valid;
        logic          wrap;
        logic          sel_err;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mux_scan_n_if #(.N(N), .W(W), .SW(SW)) bus ();

    mux_scan_n #(.N(N), .W(W), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: channel, cycles spent on it, output register.
    int           m_s;
    int           m_cnt;
    logic [W-1:0] m_y;
    logic         m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_s     = 0;
        m_cnt   = 0;
        m_y     = '0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        int   nxt;
        int   cnt_n;
        logic wr;
        logic er;
        obs_t o;
        logic [N*W-1:0] dv;
        dv    = bus.d;
        nxt   = m_s;
        cnt_n = 0;
        wr    = 1'b0;
        er    = 1'b0;
        if (bus.mode == 1'b0) begin
            if (int'(bus.s_in) < N) nxt = int'(bus.s_in);
            else er = 1'b1;
        end else if (bus.hold) begin
            cnt_n = m_cnt;
        end else if (m_cnt == DWELL - 1) begin
            nxt = (m_s + 1) % N;
            wr  = (m_s == N - 1);
        end else begin
            cnt_n = m_cnt + 1;
        end
        if (bus.en) begin
            m_y     = dv[m_s*W +: W];
            m_valid = (nxt == m_s);
        end else begin
            m_valid = 1'b0;
        end
        m_s     = nxt;
        m_cnt   = cnt_n;
        o.y       = m_y;
        o.s       = SW'(m_s);
        o.valid   = m_valid;
        o.wrap    = wr;
        o.sel_err = er;
        exp_q.push_back(o);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_y"}, 32'(bus.y), 32'd0);
        chk({tag, "_s"}, 32'(bus.s), 32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_wrap"}, 32'(bus.wrap), 32'd0);
        chk({tag, "_sel_err"}, 32'(bus.sel_err), 32'd0);
    endtask

    task automatic run_until(input string tag, input int s_want, input int cnt_want);
        int i;
        i = 0;
        while (!(m_s == s_want && m_cnt == cnt_want) && i < 40) begin
            cycle();
            i++;
        end
        if (!(m_s == s_want && m_cnt == cnt_want)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scan point s=%0d cnt=%0d not reached, at s=%0d cnt=%0d",
                     tag, s_want, cnt_want, m_s, m_cnt);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t o;
            o = exp_q.pop_front();
            chk("y", 32'(bus.y), 32'(o.y));
            chk("s", 32'(bus.s), 32'(o.s));
            chk("valid", 32'(bus.valid), 32'(o.valid));
            chk("wrap", 32'(bus.wrap), 32'(o.wrap));
            chk("sel_err", 32'(bus.sel_err), 32'(o.sel_err));
        end
    end

    initial begin
        bus.d    = '0;
        bus.mode = MODE_MANUAL;
        bus.s_in = '0;
        bus.en   = 1'b0;
        bus.hold = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #20;
        check_zero("reset");

        // Manual select after reset release.
        bus.d    = 24'h332211;
        bus.en   = 1'b1;
        bus.s_in = 2'd2;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();

        // Out-of-range manual select, then back in range.
        bus.s_in = 2'd3;
        cycle();
        bus.s_in = 2'd2;
        repeat (2) cycle();
        bus.s_in = 2'd0;
        repeat (2) cycle();

        // Scan with wrap-around.
        bus.mode = MODE_SCAN;
        for (int i = 0; i < 20; i++) begin
            bus.s_in = SW'($urandom_range(0, 3));
            cycle();
        end

        // Hold mid-dwell.
        run_until("hold_point", 1, 2);
        bus.hold = 1'b1;
        repeat (5) cycle();
        bus.hold = 1'b0;
        repeat (4) cycle();

        // Enable gating while data toggles.
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.d = N*W'($urandom);
            cycle();
        end
        bus.en = 1'b1;
        repeat (3) cycle();

        // Asynchronous reset between edges mid-scan.
        run_until("reset_point", 2, 3);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        @(negedge clk);
        check_zero("reset_held");
        rst_n = 1'b1;
        model_reset();
        repeat (6) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.d    = N*W'($urandom);
            bus.s_in = SW'($urandom_range(0, 3));
            bus.en   = ($urandom_range(0, 7) != 0);
            bus.hold = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) bus.mode = ~bus.mode;
            cycle();
        end

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
